// File: rtl/eth_recv_dds_mc.sv
// eth_recv_dds_mc
// Multi-channel Ethernet DDS configuration receiver. It parses UDP payload
// words into per-channel DDS settings. Each packet is validated against the
// magic value, the channel index and the length before anything changes.
// Payload fields are staged in shadow registers. A valid packet copies them
// into one channel in a single cycle.
// Optional feature: define DDS_CFG_CHKSUM_EN to require a seventh word.
// That word must equal the wrapping sum of w0..w5. The packet is then 28
// bytes, and a mismatch rejects it with err_code 6.
module eth_recv_dds_mc #(
  parameter int          NUM_CH  = 2,
  parameter logic [15:0] MAGIC   = 16'hDD5C,
  parameter logic [8:0]  AMP_MAX = 9'd256
) (
  input  logic                 eth_rx_clk,
  input  logic                 rst,
  input  logic                 rec_pkt_done,
  input  logic                 rec_en,
  input  logic [31:0]          rec_data,
  input  logic [15:0]          rec_byte_num,
  output logic [NUM_CH*4-1:0]  wave_select,
  output logic [NUM_CH*9-1:0]  amp_ctl,
  output logic [NUM_CH*32-1:0] freq_ctl,
  output logic [NUM_CH*32-1:0] min_ctl,
  output logic [NUM_CH*12-1:0] phase_ctl,
  output logic [NUM_CH-1:0]    cfg_update,
  output logic                 pkt_err,
  output logic [2:0]           err_code,
  output logic [15:0]          err_cnt
);

`ifdef DDS_CFG_CHKSUM_EN
  localparam logic [2:0] NW = 3'd7;
`else
  localparam logic [2:0] NW = 3'd6;
`endif
  localparam logic [15:0] PKT_BYTES = {11'd0, NW, 2'b00};
  localparam logic [7:0]  NUM_CH8   = 8'(NUM_CH);

  localparam logic [1:0] S_HDR    = 2'd0;
  localparam logic [1:0] S_PAY    = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_MAGIC = 3'd1;
  localparam logic [2:0] E_CH    = 3'd2;
  localparam logic [2:0] E_SHORT = 3'd3;
  localparam logic [2:0] E_OVR   = 3'd4;
  localparam logic [2:0] E_BYTES = 3'd5;
`ifdef DDS_CFG_CHKSUM_EN
  localparam logic [2:0] E_CHK   = 3'd6;
`endif

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [3:0]  r_ch;
  logic [2:0]  r_err_pend;
  logic [3:0]  r_sh_wave;
  logic [8:0]  r_sh_amp;
  logic [31:0] r_sh_freq;
  logic [31:0] r_sh_min;
  logic [11:0] r_sh_phase;
`ifdef DDS_CFG_CHKSUM_EN
  logic [31:0] r_sum;
  logic [31:0] r_sh_chk;
  logic [31:0] w_chk;
`endif
  logic        r_pkt_err;
  logic [2:0]  r_err_code;
  logic [15:0] r_err_cnt;
  logic [NUM_CH-1:0] r_upd;

  logic [1:0]  w_nstate;
  logic        w_fire;
  logic [2:0]  w_fcode;
  logic [2:0]  w_pend;
  logic        w_store;
  logic        w_hdr_ok;
  logic [2:0]  w_hdr_code;
  logic [2:0]  w_cnt_fin;
  logic [8:0]  w_amp;
  logic [NUM_CH-1:0] w_commit;

  assign w_hdr_code = (rec_data[31:16] != MAGIC) ? E_MAGIC :
                      (rec_data[7:0] >= NUM_CH8)  ? E_CH    : E_NONE;
  // The final word may arrive in the same cycle as rec_pkt_done, so it is counted first.
  assign w_cnt_fin  = r_cnt + {2'b00, rec_en};
  assign w_amp      = (rec_data[8:0] > AMP_MAX) ? AMP_MAX : rec_data[8:0];
`ifdef DDS_CFG_CHKSUM_EN
  assign w_chk      = (rec_en && r_cnt == 3'd6) ? rec_data : r_sh_chk;
`endif

  // Next-state logic plus error detection. The first error seen in a packet wins.
  always_comb begin
    w_nstate = r_state;
    w_fire   = 1'b0;
    w_fcode  = E_NONE;
    w_pend   = r_err_pend;
    w_store  = 1'b0;
    w_hdr_ok = 1'b0;
    case (r_state)
      S_HDR: begin
        if (rec_en) begin
          if (w_hdr_code != E_NONE) begin
            if (rec_pkt_done) begin
              w_fire  = 1'b1;
              w_fcode = w_hdr_code;
            end else begin
              w_pend   = w_hdr_code;
              w_nstate = S_DROP;
            end
          end else begin
            w_hdr_ok = 1'b1;
            if (rec_pkt_done) begin
              w_fire  = 1'b1;
              w_fcode = E_SHORT;
            end else begin
              w_nstate = S_PAY;
            end
          end
        end else if (rec_pkt_done) begin
          w_fire  = 1'b1;
          w_fcode = E_SHORT;
        end
      end
      S_PAY: begin
        if (rec_en && r_cnt == NW) begin
          if (rec_pkt_done) begin
            w_fire   = 1'b1;
            w_fcode  = E_OVR;
            w_nstate = S_HDR;
          end else begin
            w_pend   = E_OVR;
            w_nstate = S_DROP;
          end
        end else begin
          w_store = rec_en;
          if (rec_pkt_done) begin
            w_nstate = S_HDR;
            if (w_cnt_fin != NW) begin
              w_fire  = 1'b1;
              w_fcode = E_SHORT;
            end else if (rec_byte_num != PKT_BYTES) begin
              w_fire  = 1'b1;
              w_fcode = E_BYTES;
`ifdef DDS_CFG_CHKSUM_EN
            end else if (r_sum != w_chk) begin
              w_fire  = 1'b1;
              w_fcode = E_CHK;
`endif
            end else begin
              w_nstate = S_COMMIT;
            end
          end
        end
      end
      S_DROP: begin
        if (rec_pkt_done) begin
          w_fire   = 1'b1;
          w_fcode  = r_err_pend;
          w_nstate = S_HDR;
        end
      end
      S_COMMIT: w_nstate = S_HDR;
      default:  w_nstate = S_HDR;
    endcase
  end

  // FSM state, word counter, channel latch and shadow staging of payload words.
  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HDR;
      r_cnt      <= 3'd0;
      r_ch       <= 4'd0;
      r_err_pend <= E_NONE;
      r_sh_wave  <= 4'd0;
      r_sh_amp   <= 9'd0;
      r_sh_freq  <= 32'd0;
      r_sh_min   <= 32'd0;
      r_sh_phase <= 12'd0;
`ifdef DDS_CFG_CHKSUM_EN
      r_sum      <= 32'd0;
      r_sh_chk   <= 32'd0;
`endif
    end else begin
      r_state    <= w_nstate;
      r_err_pend <= w_pend;
      if (w_hdr_ok) begin
        r_ch  <= rec_data[3:0];
        r_cnt <= 3'd1;
`ifdef DDS_CFG_CHKSUM_EN
        r_sum <= rec_data;
`endif
      end
      if (w_store) begin
        r_cnt <= r_cnt + 3'd1;
        case (r_cnt)
          3'd1: r_sh_wave  <= rec_data[3:0];
          3'd2: r_sh_amp   <= w_amp;
          3'd3: r_sh_freq  <= rec_data;
          3'd4: r_sh_min   <= rec_data;
          3'd5: r_sh_phase <= rec_data[11:0];
`ifdef DDS_CFG_CHKSUM_EN
          3'd6: r_sh_chk   <= rec_data;
`endif
          default: ;
        endcase
`ifdef DDS_CFG_CHKSUM_EN
        if (r_cnt <= 3'd5) r_sum <= r_sum + rec_data;
`endif
      end
    end
  end

  // Reject reporting: a one-cycle pulse, a sticky code and a saturating count.
  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) begin
      r_pkt_err  <= 1'b0;
      r_err_code <= E_NONE;
      r_err_cnt  <= 16'd0;
    end else begin
      r_pkt_err <= w_fire;
      if (w_fire) begin
        r_err_code <= w_fcode;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  // The commit strobe is registered, so it lines up with the new channel values.
  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) r_upd <= '0;
    else     r_upd <= w_commit;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [3:0]  r_wave;
    logic [8:0]  r_amp;
    logic [31:0] r_freq;
    logic [31:0] r_min;
    logic [11:0] r_phase;

    assign w_commit[g] = (r_state == S_COMMIT) && (r_ch == 4'(g));

    // Copy the shadow registers into this channel only when it is the one addressed.
    always_ff @(posedge eth_rx_clk or posedge rst) begin
      if (rst) begin
        r_wave  <= 4'd0;
        r_amp   <= 9'd256;
        r_freq  <= 32'd3615292;
        r_min   <= 32'd0;
        r_phase <= 12'd1024;
      end else if (w_commit[g]) begin
        r_wave  <= r_sh_wave;
        r_amp   <= r_sh_amp;
        r_freq  <= r_sh_freq;
        r_min   <= r_sh_min;
        r_phase <= r_sh_phase;
      end
    end

    assign wave_select[4*g +: 4]  = r_wave;
    assign amp_ctl[9*g +: 9]      = r_amp;
    assign freq_ctl[32*g +: 32]   = r_freq;
    assign min_ctl[32*g +: 32]    = r_min;
    assign phase_ctl[12*g +: 12]  = r_phase;
  end

  assign cfg_update = r_upd;
  assign pkt_err    = r_pkt_err;
  assign err_code   = r_err_code;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_eth_recv_dds_mc.sv
// Scoreboard bench for eth_recv_dds_mc. The driver predicts each packet's outcome
// from the packet-format rules. A negedge monitor pops the predictions and compares
// them against the DUT, and it compares every output on every cycle.
`timescale 1ns/1ps
module tb_eth_recv_dds_mc;
  localparam int NUM_CH = 2;
`ifdef DDS_CFG_CHKSUM_EN
  localparam int N = 7;
`else
  localparam int N = 6;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  logic en = 1'b0;
  logic [31:0] data = 32'd0;
  logic [15:0] bn = 16'd0;
  logic [NUM_CH*4-1:0]  wave_select;
  logic [NUM_CH*9-1:0]  amp_ctl;
  logic [NUM_CH*32-1:0] freq_ctl;
  logic [NUM_CH*32-1:0] min_ctl;
  logic [NUM_CH*12-1:0] phase_ctl;
  logic [NUM_CH-1:0]    cfg_update;
  logic                 pkt_err;
  logic [2:0]           err_code;
  logic [15:0]          err_cnt;

  eth_recv_dds_mc #(.NUM_CH(NUM_CH)) dut (
    .eth_rx_clk(clk), .rst(rst), .rec_pkt_done(done), .rec_en(en),
    .rec_data(data), .rec_byte_num(bn), .wave_select(wave_select),
    .amp_ctl(amp_ctl), .freq_ctl(freq_ctl), .min_ctl(min_ctl),
    .phase_ctl(phase_ctl), .cfg_update(cfg_update), .pkt_err(pkt_err),
    .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          commit;
    int          ch;
    logic [3:0]  wave;
    logic [8:0]  amp;
    logic [31:0] freq;
    logic [31:0] mn;
    logic [11:0] ph;
    logic [2:0]  code;
    logic [15:0] cnt;
    int          cyc;
  } ev_t;

  ev_t q[$];
  logic [31:0] pkt_w[$];
  int m_cnt = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Build a packet from its fields. In checksum mode, append the wrapping sum.
  task automatic mk_pkt(input logic [31:0] hdr, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5);
    logic [31:0] s;
    pkt_w.delete();
    pkt_w.push_back(hdr); pkt_w.push_back(w1); pkt_w.push_back(w2);
    pkt_w.push_back(w3);  pkt_w.push_back(w4); pkt_w.push_back(w5);
    s = 32'd0;
    for (int i = 0; i < 6; i++) s = s + pkt_w[i];
`ifdef DDS_CFG_CHKSUM_EN
    pkt_w.push_back(s);
`endif
  endtask

  // Reference model: classify the whole packet, then queue the expected response.
  function automatic void predict(input logic [15:0] b, input int dc);
    ev_t e;
    int n;
    logic [2:0] code;
    logic [31:0] w0, s;
    logic [8:0] a;
    n = pkt_w.size();
    code = 3'd0;
    w0 = (n > 0) ? pkt_w[0] : 32'd0;
    if (n == 0) code = 3'd3;
    else if (w0[31:16] != 16'hDD5C) code = 3'd1;
    else if (w0[7:0] >= NUM_CH) code = 3'd2;
    else if (n > N) code = 3'd4;
    else if (n < N) code = 3'd3;
    else if (b != 16'(4*N)) code = 3'd5;
`ifdef DDS_CFG_CHKSUM_EN
    else begin
      s = 32'd0;
      for (int i = 0; i < 6; i++) s = s + pkt_w[i];
      if (s != pkt_w[6]) code = 3'd6;
    end
`endif
    e.code = code; e.ch = 0; e.wave = 0; e.amp = 0; e.freq = 0; e.mn = 0; e.ph = 0; e.cnt = 0;
    if (code != 3'd0) begin
      if (m_cnt < 65535) m_cnt++;
      e.commit = 1'b0;
      e.cnt    = 16'(m_cnt);
      e.cyc    = dc + 1;
    end else begin
      a = pkt_w[2][8:0];
      e.commit = 1'b1;
      e.ch     = int'(w0[7:0]);
      e.wave   = pkt_w[1][3:0];
      e.amp    = (a > 9'd256) ? 9'd256 : a;
      e.freq   = pkt_w[3];
      e.mn     = pkt_w[4];
      e.ph     = pkt_w[5][11:0];
      e.cyc    = dc + 2;
    end
    q.push_back(e);
  endfunction

  // Drive pkt_w. rec_pkt_done goes either with the last word or one cycle later.
  task automatic send_pkt(input logic [15:0] b, input bit sep, input bit gappy);
    int n;
    n = pkt_w.size();
    for (int i = 0; i < n; i++) begin
      if (gappy && ($urandom_range(0, 2) == 0)) begin
        @(posedge clk); #1; en = 1'b0; done = 1'b0;
      end
      @(posedge clk); #1;
      en = 1'b1; data = pkt_w[i]; bn = b;
      done = (!sep && i == n - 1);
      if (done) predict(b, cyc);
    end
    if (sep || n == 0) begin
      @(posedge clk); #1;
      en = 1'b0; data = $urandom; done = 1'b1; bn = b;
      predict(b, cyc);
    end
    @(posedge clk); #1;
    en = 1'b0; done = 1'b0;
  endtask

  logic [3:0]  t_wave [NUM_CH];
  logic [8:0]  t_amp  [NUM_CH];
  logic [31:0] t_freq [NUM_CH];
  logic [31:0] t_min  [NUM_CH];
  logic [11:0] t_ph   [NUM_CH];
  logic [2:0]  x_code;
  logic [15:0] x_cnt;

  // Monitor: pop predictions when the DUT reports an event, then compare all outputs.
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        t_wave[c] = 4'd0; t_amp[c] = 9'd256; t_freq[c] = 32'd3615292;
        t_min[c] = 32'd0; t_ph[c] = 12'd1024;
      end
      x_code = 3'd0; x_cnt = 16'd0;
      chk("rst_cfg_update", 32'(cfg_update), 32'd0);
      chk("rst_pkt_err", 32'(pkt_err), 32'd0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        total++; bad++;
        $display("FAIL evt_missing act=none exp=event_at_cyc_%0d now=%0d", e.cyc, cyc);
      end
      if (cfg_update != '0 || pkt_err) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL evt_unexpected act=upd_%b_err_%b exp=none cyc=%0d", cfg_update, pkt_err, cyc);
        end else begin
          e = q.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          if (e.commit) begin
            chk("cfg_update", 32'(cfg_update), 32'(1 << e.ch));
            chk("pkt_err_on_commit", 32'(pkt_err), 32'd0);
            t_wave[e.ch] = e.wave; t_amp[e.ch] = e.amp; t_freq[e.ch] = e.freq;
            t_min[e.ch] = e.mn; t_ph[e.ch] = e.ph;
          end else begin
            chk("pkt_err", 32'(pkt_err), 32'd1);
            chk("cfg_update_on_err", 32'(cfg_update), 32'd0);
            x_code = e.code; x_cnt = e.cnt;
          end
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      chk("ch_wave",  32'(wave_select[4*c +: 4]), 32'(t_wave[c]));
      chk("ch_amp",   32'(amp_ctl[9*c +: 9]),     32'(t_amp[c]));
      chk("ch_freq",  freq_ctl[32*c +: 32],       t_freq[c]);
      chk("ch_min",   min_ctl[32*c +: 32],        t_min[c]);
      chk("ch_phase", 32'(phase_ctl[12*c +: 12]), 32'(t_ph[c]));
    end
    chk("err_code", 32'(err_code), 32'(x_code));
    chk("err_cnt",  32'(err_cnt),  32'(x_cnt));
  end

  initial begin : stim
    logic [31:0] hdr;
    logic [15:0] b;
    int r, ch, len;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Valid channel-1 packet; channel 0 must keep its reset values.
    mk_pkt(32'hDD5C0001, 32'd2, 32'd100, 32'h00123456, 32'd5, 32'd512);
    send_pkt(16'(4*N), 1'b0, 1'b0);
    // Out-of-range channel index.
    mk_pkt(32'hDD5C0005, 32'd3, 32'd50, 32'h1, 32'h2, 32'h3);
    send_pkt(16'(4*N), 1'b0, 1'b0);
    // Short packet of 4 words, then recovery with a valid channel-0 packet.
    mk_pkt(32'hDD5C0000, 32'd1, 32'd20, 32'h9, 32'h8, 32'h7);
    while (pkt_w.size() > 4) void'(pkt_w.pop_back());
    send_pkt(16'(4*N), 1'b1, 1'b0);
    mk_pkt(32'hDD5C0000, 32'd7, 32'd200, 32'hDEADBEEF, 32'h10, 32'hFFF);
    send_pkt(16'(4*N), 1'b0, 1'b0);
    // Amplitude above the ceiling is clamped.
    mk_pkt(32'hDD5C0000, 32'd1, 32'h000001FF, 32'h11, 32'h22, 32'h33);
    send_pkt(16'(4*N), 1'b1, 1'b0);

    // Reset after w3 of a valid packet; nothing may commit, then a clean packet.
    mk_pkt(32'hDD5C0001, 32'd4, 32'd10, 32'h55, 32'h66, 32'h77);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; en = 1'b1; data = pkt_w[i]; done = 1'b0; bn = 16'(4*N);
    end
    @(posedge clk); #1;
    en = 1'b0; rst = 1'b1; q.delete(); m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mk_pkt(32'hDD5C0001, 32'd9, 32'd255, 32'hCAFEF00D, 32'd1, 32'd4095);
    send_pkt(16'(4*N), 1'b0, 1'b0);

`ifdef DDS_CFG_CHKSUM_EN
    // Wrong checksum word.
    mk_pkt(32'hDD5C0000, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3);
    pkt_w[6] = pkt_w[6] ^ 32'h1;
    send_pkt(16'(4*N), 1'b0, 1'b0);
`endif

    // Randomized packets that mix good packets with every kind of error.
    repeat (300) begin
      r = $urandom_range(0, 99);
      ch = (r < 8) ? NUM_CH + $urandom_range(0, 5) : $urandom_range(0, NUM_CH - 1);
      hdr = {16'hDD5C, 8'h00, 8'(ch)};
      if (r >= 8 && r < 14) hdr[31:16] = hdr[31:16] ^ 16'($urandom_range(1, 65535));
      mk_pkt(hdr, $urandom, $urandom, $urandom, $urandom, $urandom);
      if (r >= 14 && r < 26) begin
        len = $urandom_range(0, N + 2);
        while (pkt_w.size() > len) void'(pkt_w.pop_back());
        while (pkt_w.size() < len) pkt_w.push_back($urandom);
      end
`ifdef DDS_CFG_CHKSUM_EN
      if (r >= 30 && r < 36 && pkt_w.size() == N) pkt_w[N-1] = pkt_w[N-1] ^ 32'h100;
`endif
      b = (r >= 26 && r < 30) ? 16'(4*N + 4) : 16'(4*N);
      send_pkt(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Error-count saturation: back-to-back empty packets, then bad-magic packets.
    while (m_cnt < 16'hFFFE) begin
      @(posedge clk); #1;
      en = 1'b0; done = 1'b1; bn = 16'd0;
      pkt_w.delete();
      predict(16'd0, cyc);
    end
    @(posedge clk); #1 done = 1'b0;
    repeat (3) begin
      mk_pkt(32'h12340001, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
      send_pkt(16'(4*N), 1'b0, 1'b0);
    end

    repeat (4) @(posedge clk);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain act=%0d_pending exp=0_pending", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_recv_dds_mc.md
Name: eth_recv_dds_mc

Overview:
- Multi-channel successor to the single-channel Ethernet DDS config receiver.
- Parses UDP payload words from the eth RX path into per-channel DDS settings for NUM_CH generators.
- Each packet is validated (magic, channel index, length) before any output changes; config is staged in shadow registers and committed atomically.
- Sits between the eth UDP receive logic and the DDS cores, entirely in the eth_rx_clk domain.

Parameters:
- NUM_CH, 2, number of DDS channels (1..16).
- MAGIC, 16'hDD5C, required value of header word bits [31:16].
- AMP_MAX, 9'd256, amplitude clamp ceiling.

Ports:
- eth_rx_clk  input  1  receive clock
- rst  input  1  asynchronous, active-high reset
- rec_pkt_done  input  1  single-cycle end-of-packet pulse; may coincide with the last rec_en or follow it
- rec_en  input  1  rec_data valid
- rec_data  input  32  payload word
- rec_byte_num  input  16  packet payload byte count; valid at rec_pkt_done
- wave_select  output  NUM_CH*4  per-channel waveform select; ch n at [4n+3:4n]
- amp_ctl  output  NUM_CH*9  per-channel amplitude
- freq_ctl  output  NUM_CH*32  per-channel frequency word
- min_ctl  output  NUM_CH*32  per-channel minimum resolution
- phase_ctl  output  NUM_CH*12  per-channel phase
- cfg_update  output  NUM_CH  one-cycle pulse on the channel just committed
- pkt_err  output  1  one-cycle pulse on a rejected packet
- err_code  output  3  code of the last rejected packet; sticky
- err_cnt  output  16  rejected-packet count, saturating at 16'hFFFF

Behaviour:
- Packet format (32-bit words), with N = 6:
  - w0 = {MAGIC, 8'h00, ch_idx[7:0]}
  - w1 = wave in [3:0]
  - w2 = amp in [8:0]
  - w3 = freq
  - w4 = min
  - w5 = phase in [11:0]
- Reset values, every channel: wave 0, amp 256, freq 3615292, min 0, phase 1024. cfg_update 0, pkt_err 0, err_code 0, err_cnt 0.
- Reset is asynchronous; asserting it mid-packet discards the shadow registers and returns the FSM to S_HDR.
- FSM states:
  - S_HDR (idle). A rec_en word is checked as the header.
    - Magic mismatch or ch_idx >= NUM_CH: latch the error, go to S_DROP.
    - Otherwise latch ch_idx, word count = 1, go to S_PAY.
  - S_PAY. Each rec_en word is stored in the shadow register selected by word count; count increments.
    - A word arriving when count == N: overrun, go to S_DROP.
  - S_DROP. Ignores data until rec_pkt_done, then returns to S_HDR.
  - S_COMMIT. Lasts one cycle. Copies the shadow registers into channel ch_idx, pulses cfg_update[ch_idx], returns to S_HDR.
- At rec_pkt_done:
  - If rec_en is also high that cycle, the word is counted first.
  - Valid packet: count == N, rec_byte_num == 4*N, and no earlier error. Go to S_COMMIT.
  - Otherwise pulse pkt_err in the next cycle and go to S_HDR.
- Outputs change exactly 2 cycles after the cycle carrying the final word plus rec_pkt_done. Other channels never change.
- rec_pkt_done arriving in S_HDR with no words (empty packet): short error. rec_en in the same cycle as a pulse in S_DROP is ignored.
- Amplitude: if rec_data[8:0] > AMP_MAX, AMP_MAX is stored. Upper data bits of the narrow fields are ignored.
- err_code values: 1 = magic, 2 = bad channel, 3 = short (count < N), 4 = overrun, 5 = byte_num mismatch, 6 = checksum.
- When several errors apply, the first detected is recorded.
- err_cnt increments once per pkt_err and holds at 16'hFFFF.

Optional Feature:
- Macro: DDS_CFG_CHKSUM_EN.
- Defined:
  - N = 7 and the required rec_byte_num is 28.
  - w6 must equal the 32-bit wrapping sum of w0..w5; a mismatch rejects the packet with err_code 6 and no commit.
- Undefined: N = 6, no checksum logic, and code 6 never occurs.

Test Plan:
- Reset, then a valid packet: w0 = 32'hDD5C0001, wave 2, amp 100, freq 32'h00123456, min 5, phase 512, with rec_pkt_done on the last word.
  - Ch1 fields update 2 cycles later and cfg_update = 2'b10.
  - Ch0 holds its reset values (0/256/3615292/0/1024).
- Header 32'hDD5C0005 with NUM_CH = 2 and a full packet: pkt_err pulse, err_code = 2, err_cnt = 1, no output change.
- Only 4 words, then rec_pkt_done: err_code = 3, no commit. Then a valid ch0 packet commits correctly, showing recovery.
- Amp word 32'h000001FF: amp_ctl for the channel = 256.
- rst asserted after w3 of a valid packet, then released: all outputs at reset values. The next valid packet commits normally.
- Force err_cnt to 16'hFFFE, send 3 bad-magic packets: err_cnt = 16'hFFFF and holds. With DDS_CFG_CHKSUM_EN, a wrong w6 gives err_code = 6.
